// File: rtl/ni_packet_sender_pkg.sv
// Shared network-interface definitions: flit geometry and the packet sender's state encoding.
package hemps_defaults;

  localparam int TAM_FLIT   = 16;
  localparam int METADEFLIT = TAM_FLIT / 2;

  typedef logic [TAM_FLIT-1:0]   regflit;
  typedef logic [METADEFLIT-1:0] regmetadeflit;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEAD,
    S_SIZE,
    S_PAY
  } sender_state_t;

endpackage

// File: rtl/ni_packet_sender_if.sv
// Descriptor, payload and router-link signals of the packet sender.
// master = the sender itself, slave = the environment feeding it and the router port it drives.
interface ni_packet_sender_if;
  import hemps_defaults::*;

  logic         req_valid;
  logic         req_ready;
  regmetadeflit req_target;
  regflit       req_size;

  logic         pay_valid;
  logic         pay_ready;
  regflit       pay_data;

  logic         clock_tx;
  logic         tx;
  regflit       data_out;
  logic         credit_i;

  modport master (
    input  req_valid, req_target, req_size,
    input  pay_valid, pay_data,
    input  credit_i,
    output req_ready, pay_ready,
    output clock_tx, tx, data_out
  );

  modport slave (
    output req_valid, req_target, req_size,
    output pay_valid, pay_data,
    output credit_i,
    input  req_ready, pay_ready,
    input  clock_tx, tx, data_out
  );

endinterface

// File: rtl/ni_packet_sender.sv
// Credit-based flit transmitter: serialises header, size and payload flits into a router input port.
// Optional NI_SENDER_STALL_COUNT_EN adds a saturating stall_cycles counter output.
module ni_packet_sender
  import hemps_defaults::*;
(
  input  logic               clock,
  input  logic               reset,
  ni_packet_sender_if.master ni,
  output logic               busy,
`ifdef NI_SENDER_STALL_COUNT_EN
  output regflit             stall_cycles,
`endif
  output logic               pkt_done
);

  sender_state_t state, state_next;
  logic          tx_q, tx_d, done_d;
  regflit        data_q, data_d;
  regflit        load_cnt, load_d;
  regflit        size_q, size_d;
  logic          accept, pay_ready_w, pay_take;

  assign accept = (state == S_IDLE) && ni.req_valid;

  // The first payload flit is taken while the size flit leaves, keeping one flit per cycle.
  assign pay_ready_w = ((state == S_PAY) && (load_cnt != '0) && (!tx_q || ni.credit_i)) ||
                       ((state == S_SIZE) && ni.credit_i && (size_q != '0));
  assign pay_take    = ni.pay_valid && pay_ready_w;

  assign ni.req_ready = (state == S_IDLE);
  assign ni.pay_ready = pay_ready_w;
  assign ni.clock_tx  = clock;
  assign ni.tx        = tx_q;
  assign ni.data_out  = data_q;
  assign busy         = (state != S_IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      tx_q     <= 1'b0;
      data_q   <= '0;
      pkt_done <= 1'b0;
      load_cnt <= '0;
      size_q   <= '0;
    end else begin
      state    <= state_next;
      tx_q     <= tx_d;
      data_q   <= data_d;
      pkt_done <= done_d;
      load_cnt <= load_d;
      size_q   <= size_d;
    end
  end

  always_comb begin
    state_next = state;
    tx_d       = tx_q;
    data_d     = data_q;
    done_d     = 1'b0;
    load_d     = load_cnt;
    size_d     = size_q;
    unique case (state)
      S_IDLE: begin
        if (ni.req_valid) begin
          size_d     = ni.req_size;
          load_d     = ni.req_size;
          tx_d       = 1'b1;
          data_d     = regflit'(ni.req_target);
          state_next = S_HEAD;
        end
      end
      S_HEAD: begin
        if (ni.credit_i) begin
          data_d     = size_q;
          state_next = S_SIZE;
        end
      end
      S_SIZE: begin
        if (ni.credit_i) begin
          if (size_q == '0) begin
            tx_d       = 1'b0;
            done_d     = 1'b1;
            state_next = S_IDLE;
          end else begin
            state_next = S_PAY;
            if (pay_take) begin
              data_d = ni.pay_data;
              tx_d   = 1'b1;
              load_d = load_cnt - 1'b1;
            end else begin
              tx_d = 1'b0;
            end
          end
        end
      end
      S_PAY: begin
        if (pay_take) begin
          data_d = ni.pay_data;
          tx_d   = 1'b1;
          load_d = load_cnt - 1'b1;
        end else if (tx_q && ni.credit_i) begin
          tx_d = 1'b0;
          if (load_cnt == '0) begin
            done_d     = 1'b1;
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

`ifdef NI_SENDER_STALL_COUNT_EN
  // Counts cycles the router withholds credit from a pending flit; survives the packet end.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
    end else if (accept) begin
      stall_cycles <= '0;
    end else if (tx_q && !ni.credit_i && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ni_packet_sender.sv
// Self-checking bench for ni_packet_sender: directed scenarios plus randomized traffic,
// all checked against a flit-queue reference model of the packet format and credit rules.
module tb_ni_packet_sender;
  import hemps_defaults::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic busy;
  logic pkt_done;
`ifdef NI_SENDER_STALL_COUNT_EN
  regflit stall_cycles;
`endif

  ni_packet_sender_if link ();

  ni_packet_sender dut (
    .clock        (clock),
    .reset        (reset),
    .ni           (link),
    .busy         (busy),
`ifdef NI_SENDER_STALL_COUNT_EN
    .stall_cycles (stall_cycles),
`endif
    .pkt_done     (pkt_done)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: flits still owed to the router, packet-end markers, payloads not yet taken.
  regflit exp_q[$];
  bit     end_q[$];
  regflit src_q[$];
  regflit pend_pay[$];
  bit     done_due   = 1'b0;
  int     accept_cnt = 0;
  int     xfer_cnt   = 0;
  int     stall_exp  = 0;
  bit     rand_mode  = 1'b0;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
    if (rand_mode) begin
      link.credit_i  = ($urandom_range(0, 3) != 0);
      link.pay_valid = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic send_req(input logic [7:0] tgt, input logic [15:0] sz);
    int start;
    int n;
    link.req_target = tgt;
    link.req_size   = sz;
    link.req_valid  = 1'b1;
    start = accept_cnt;
    n = 0;
    while (accept_cnt == start && n < 300) begin
      tick();
      n++;
    end
    link.req_valid = 1'b0;
    check_output("accept", accept_cnt - start, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      tick();
      n++;
    end
    check_output("drain", exp_q.size(), 0);
    tick();
    tick();
  endtask

  task automatic wait_flit(input logic [15:0] value);
    int n;
    n = 0;
    while (!(link.tx && link.data_out == value) && n < 50) begin
      tick();
      n++;
    end
    check_output("reach_flit", link.data_out, value);
  endtask

  // Model update: checks at the falling edge, state advance just after the rising edge.
  initial begin : monitor
    bit     acc, xfer, take, exp_tx, legal, last;
    int     diff;
    regflit p;
    link.pay_data = 16'hDEAD;
    forever begin
      @(negedge clock);
      acc = 1'b0; xfer = 1'b0; take = 1'b0; exp_tx = 1'b0;
      if (!reset) begin
        check_output("rst_tx", link.tx, 0);
        check_output("rst_data", link.data_out, 0);
        check_output("rst_done", pkt_done, 0);
        check_output("rst_req_ready", link.req_ready, 1);
        check_output("rst_pay_ready", link.pay_ready, 0);
        exp_q.delete(); end_q.delete(); src_q.delete();
        done_due  = 1'b0;
        stall_exp = 0;
      end else begin
        diff   = exp_q.size() - src_q.size();
        exp_tx = (diff != 0);
        legal  = (src_q.size() != 0) && ((diff == 0) || (diff == 1 && link.tx && link.credit_i));
        check_output("tx", link.tx, exp_tx);
        if (link.tx && exp_q.size() != 0) check_output("data_out", link.data_out, exp_q[0]);
        check_output("pkt_done", pkt_done, done_due);
        check_output("req_ready", link.req_ready, exp_q.size() == 0);
        check_output("busy", busy, exp_q.size() != 0);
        check_output("pay_ready", link.pay_ready, legal);
`ifdef NI_SENDER_STALL_COUNT_EN
        check_output("stall_cycles", stall_cycles, stall_exp);
`endif
        take = link.pay_valid && link.pay_ready;
        xfer = link.tx && link.credit_i;
        acc  = link.req_valid && (exp_q.size() == 0);
      end
      @(posedge clock);
      #1;
      if (reset) begin
        done_due = 1'b0;
        if (take && src_q.size() != 0) void'(src_q.pop_front());
        if (xfer && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          last = end_q.pop_front();
          done_due = last;
          xfer_cnt++;
        end
        if (acc) stall_exp = 0;
        else if (exp_tx && !link.credit_i && stall_exp < 65535) stall_exp++;
        if (acc) begin
          exp_q.push_back(16'(link.req_target)); end_q.push_back(1'b0);
          exp_q.push_back(link.req_size);        end_q.push_back(link.req_size == 0);
          for (int i = 0; i < int'(link.req_size); i++) begin
            p = (pend_pay.size() != 0) ? pend_pay.pop_front() : 16'($urandom);
            exp_q.push_back(p);
            src_q.push_back(p);
            end_q.push_back(i == int'(link.req_size) - 1);
          end
          accept_cnt++;
        end
      end
      link.pay_data = (src_q.size() != 0) ? src_q[0] : 16'hDEAD;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin : stimulus
    logic [15:0] b2b_data [8];
    bit          b2b_tx   [8];
    bit          b2b_done [8];
    int          dcount;
    int          xstart;

    link.req_valid  = 1'b0;
    link.req_target = '0;
    link.req_size   = '0;
    link.pay_valid  = 1'b0;
    link.credit_i   = 1'b1;

    tick(); tick();
    @(negedge clock);
    check_output("init_tx", link.tx, 0);
    check_output("init_data", link.data_out, 0);
    check_output("init_done", pkt_done, 0);
    check_output("init_busy", busy, 0);
    check_output("init_req_ready", link.req_ready, 1);
    tick();
    reset = 1'b1;
    tick();

    $display("[TB] basic packet size 2");
    link.pay_valid = 1'b1;
    pend_pay = '{16'hAAAA, 16'hBBBB};
    send_req(8'h11, 16'd2);
    b2b_data[0] = 16'h0011; b2b_data[1] = 16'h0002; b2b_data[2] = 16'hAAAA; b2b_data[3] = 16'hBBBB;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check_output("basic_tx", link.tx, 1);
      check_output("basic_data", link.data_out, b2b_data[i]);
    end
    @(negedge clock);
    check_output("basic_done", pkt_done, 1);
    check_output("basic_tx_end", link.tx, 0);
    check_output("basic_req_ready", link.req_ready, 1);
    wait_idle();

    $display("[TB] empty packet");
    send_req(8'h03, 16'd0);
    @(negedge clock);
    check_output("empty_hdr", link.data_out, 16'h0003);
    check_output("empty_pay_ready0", link.pay_ready, 0);
    @(negedge clock);
    check_output("empty_size", link.data_out, 16'h0000);
    check_output("empty_tx", link.tx, 1);
    check_output("empty_pay_ready1", link.pay_ready, 0);
    @(negedge clock);
    check_output("empty_done", pkt_done, 1);
    wait_idle();

    $display("[TB] credit stall");
    pend_pay = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
    xstart = xfer_cnt;
    send_req(8'h22, 16'd3);
    wait_flit(16'hAAAA);
    link.credit_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_output("stall_tx", link.tx, 1);
      check_output("stall_data", link.data_out, 16'hAAAA);
      tick();
    end
    link.credit_i = 1'b1;
    wait_idle();
    check_output("stall_flits", xfer_cnt - xstart, 5);
`ifdef NI_SENDER_STALL_COUNT_EN
    check_output("stall_count", stall_cycles, 3);
`endif

    $display("[TB] payload gap");
    pend_pay = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
    xstart = xfer_cnt;
    send_req(8'h33, 16'd3);
    wait_flit(16'hAAAA);
    link.pay_valid = 1'b0;
    tick();
    @(negedge clock);
    check_output("gap_tx0", link.tx, 0);
    tick();
    link.pay_valid = 1'b1;
    @(negedge clock);
    check_output("gap_tx1", link.tx, 0);
    wait_idle();
    check_output("gap_flits", xfer_cnt - xstart, 5);

    $display("[TB] reset mid packet");
    xstart = xfer_cnt;
    send_req(8'h44, 16'd4);
    while (xfer_cnt - xstart < 2) tick();
    reset = 1'b0;
    #1;
    check_output("async_tx", link.tx, 0);
    check_output("async_data", link.data_out, 0);
    check_output("async_busy", busy, 0);
    tick(); tick();
    reset = 1'b1;
    tick();
    check_output("post_rst_ready", link.req_ready, 1);
    send_req(8'h55, 16'd1);
    @(negedge clock);
    check_output("post_rst_hdr", link.data_out, 16'h0055);
    wait_idle();

    $display("[TB] back-to-back");
    pend_pay = '{16'h1111, 16'h2222};
    send_req(8'h10, 16'd1);
    link.req_valid  = 1'b1;
    link.req_target = 8'h20;
    b2b_tx   = '{1, 1, 1, 0, 1, 1, 1, 0};
    b2b_done = '{0, 0, 0, 1, 0, 0, 0, 1};
    b2b_data = '{16'h0010, 16'h0001, 16'h1111, 16'h0000, 16'h0020, 16'h0001, 16'h2222, 16'h0000};
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (i == 4) link.req_valid = 1'b0;
      check_output("b2b_tx", link.tx, b2b_tx[i]);
      if (b2b_tx[i]) check_output("b2b_data", link.data_out, b2b_data[i]);
      check_output("b2b_done", pkt_done, b2b_done[i]);
      if (pkt_done) dcount++;
    end
    check_output("b2b_done_count", dcount, 2);
    link.req_valid = 1'b0;
    wait_idle();

    $display("[TB] randomized traffic");
    rand_mode = 1'b1;
    for (int k = 0; k < 40; k++) begin
      send_req(8'($urandom), 16'($urandom_range(0, 6)));
      if ($urandom_range(0, 2) == 0) tick();
    end
    rand_mode      = 1'b0;
    link.credit_i  = 1'b1;
    link.pay_valid = 1'b1;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
